carry_skip_adder_pipe: RTL and testbench
========================================

# carry_skip_adder_pipe

Parametrised, pipelined carry-skip adder/subtractor with a valid/ready stream interface. It generalises the team's 16-bit combinational carry-skip adder to any width and skip-block size, adds a subtract mode and signed-overflow flag, and registers the carry chain into pipeline stages so wide operands close timing. It sits in the datapath as a streaming arithmetic unit with full backpressure support.

## Interface
- WIDTH, 32: operand/sum width; must be a multiple of BLOCK*BLOCKS_PER_STAGE.
- BLOCK, 4: bits per carry-skip block.
- BLOCKS_PER_STAGE, 2: skip blocks evaluated per pipeline stage; NSTG = WIDTH/(BLOCK*BLOCKS_PER_STAGE).
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+cin, 1 = A-B-cin.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (sub: 1 = no borrow).
- ovf  out  1  signed two's-complement overflow.

## Operation
- Operand prep at input: b_eff = sub ? ~b : b; c0 = sub ? ~cin : cin. Result is a + b_eff + c0.
- Per block: p_i = a_i ^ b_eff_i, g_i = a_i & b_eff_i; ripple sum inside block; block carry-out = (&p) ? block carry-in : ripple carry-out (skip mux). Functionally equal to plain addition for all inputs.
- Stage k (0..NSTG-1) processes bits [k*SW +: SW], SW = BLOCK*BLOCKS_PER_STAGE, using the carry registered by stage k-1 (stage 0 uses c0). Unprocessed upper operand slices and completed lower sum slices travel forward in stage registers alongside a per-stage valid bit.
- Final stage outputs: sum; cout = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Flow control: adv = !out_valid || out_ready. in_ready = adv. When adv = 1 every stage register (data and valid) shifts one stage; when adv = 0 all stages hold. Beat accepted when in_valid && in_ready. Bubbles (valid = 0) propagate like beats; no compaction.
- Results emerge strictly in acceptance order; no beat dropped or duplicated under any out_ready pattern.
- sub and cin are sampled only at acceptance; later changes do not affect in-flight beats.

## Timing
- Latency: NSTG cycles from accepting edge to out_valid high (default 4). NSTG = 1 gives one-cycle registered adder.
- Throughput: one beat per cycle while out_ready = 1.
- in_ready is combinational from out_ready and out_valid (one-level path); no path from in_valid to in_ready.
- out_valid/sum/cout/ovf are registered outputs, stable while out_valid && !out_ready.
- Reset (async assert, any time including mid-stream): all valid bits 0, sum = 0, cout = 0, ovf = 0, in_ready = 1 after deassertion; in-flight beats discarded. First acceptance possible on first clock edge with rst_n high.
- Simultaneous accept at input and retire at output in the same cycle is legal and required at full rate.

## Test plan
- Reset: assert rst_n = 0 mid-stream with 3 beats in flight -> out_valid = 0, sum = 0, cout = 0, ovf = 0 immediately; no stale beat appears after release.
- Add: a = 5, b = 5, cin = 1, sub = 0 -> after 4 cycles sum = 11, cout = 0, ovf = 0; a = 0xFFFFFFFF, b = 0, cin = 1 -> sum = 0, cout = 1, ovf = 0 (full skip chain across all stages).
- Sub: a = 3, b = 5, cin = 0, sub = 1 -> sum = 0xFFFFFFFE, cout = 0, ovf = 0; a = 0x80000000, b = 1, sub = 1 -> sum = 0x7FFFFFFF, cout = 1, ovf = 1.
- Overflow: a = 0x7FFFFFFF, b = 1, cin = 0, sub = 0 -> sum = 0x80000000, ovf = 1, cout = 0.
- Backpressure: stream 8 beats back-to-back, hold out_ready = 0 for cycles 5-7 -> in_ready low during stall, outputs held, all 8 results delivered in order, none lost or duplicated.
- Parameter sweep: WIDTH = 16, BLOCK = 4, BLOCKS_PER_STAGE = 4 (NSTG = 1) and WIDTH = 64, BLOCK = 8 -> 10k random beats with random valid/ready match reference model a + b_eff + c0, latency NSTG.

Source files
------------

// File: rtl/carry_skip_adder_pipe_if.sv
// Purpose : operand/result stream bundle for carry_skip_adder_pipe.
// Ports   : in_valid/in_ready/a/b/cin/sub (operand beat), out_valid/out_ready/
//           sum/cout/ovf (result beat). master = producer/consumer side, slave = adder.
interface carry_skip_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/carry_skip_adder_pipe.sv
// Purpose : pipelined carry-skip adder/subtractor (a + b_eff + c0) with signed overflow.
// Latency : NSTG = WIDTH/(BLOCK*BLOCKS_PER_STAGE) register stages, one beat per cycle.
// Backpr. : whole pipe advances only when the output slot is empty or taken; in_ready = that.
// Ports   : clk, rst_n (async, active low), bus (slave modport of carry_skip_adder_pipe_if).
// WIDTH must be a multiple of BLOCK*BLOCKS_PER_STAGE.
module carry_skip_adder_pipe #(
  parameter int WIDTH            = 32,
  parameter int BLOCK            = 4,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  carry_skip_adder_pipe_if.slave bus
);

  localparam int SW   = BLOCK * BLOCKS_PER_STAGE;  // bits resolved per stage
  localparam int NSTG = WIDTH / SW;

  logic adv;

  // One stage slice: ripple inside each block, and a block whose bits all
  // propagate forwards its carry-in directly (skip mux), cutting the long path.
  // Returns {carry_out, sum}.
  function automatic logic [SW:0] slice_add(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          ci);
    logic [SW-1:0] s;
    logic          c;
    logic          rc;
    logic          allp;
    logic          p;
    logic          g;
    int            idx;
    s    = '0;
    c    = ci;
    rc   = ci;
    allp = 1'b1;
    p    = 1'b0;
    g    = 1'b0;
    idx  = 0;
    for (int blk = 0; blk < BLOCKS_PER_STAGE; blk++) begin
      rc   = c;
      allp = 1'b1;
      for (int j = 0; j < BLOCK; j++) begin
        idx    = blk * BLOCK + j;
        p      = x[idx] ^ y[idx];
        g      = x[idx] & y[idx];
        s[idx] = p ^ rc;
        rc     = g | (p & rc);
        allp   = allp & p;
      end
      c = allp ? c : rc;
    end
    return {c, s};
  endfunction

  // Stage k consumes operand bits [WIDTH-1 : k*SW] and resolves the lowest SW
  // of them. Only the still-unprocessed upper operand bits and the already
  // finished lower sum bits are carried forward, so registers shrink/grow
  // along the pipe instead of every stage holding full-width copies.
  for (genvar k = 0; k < NSTG; k++) begin : stg
    localparam int HI = WIDTH - k * SW;   // operand bits entering this stage
    localparam int LO = (k + 1) * SW;     // sum bits complete after this stage

    logic [HI-1:0] a_in;
    logic [HI-1:0] b_in;
    logic          c_in;
    logic          vld_in;
    logic [SW:0]   r;
    logic [LO-1:0] s_nxt;
    logic [LO-1:0] s_q;
    logic          c_q;
    logic          vld_q;

    if (k == 0) begin : src
      // Subtraction folds into addition: a - b - cin = a + ~b + ~cin.
      assign a_in   = bus.a;
      assign b_in   = bus.sub ? ~bus.b : bus.b;
      assign c_in   = bus.sub ^ bus.cin;
      assign vld_in = bus.in_valid;
      assign s_nxt  = r[SW-1:0];
    end else begin : src
      assign a_in   = stg[k-1].ops.a_q;
      assign b_in   = stg[k-1].ops.b_q;
      assign c_in   = stg[k-1].c_q;
      assign vld_in = stg[k-1].vld_q;
      assign s_nxt  = {r[SW-1:0], stg[k-1].s_q};
    end

    assign r = slice_add(a_in[SW-1:0], b_in[SW-1:0], c_in);

    // Bubbles shift exactly like beats; nothing moves while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else if (adv) begin
        vld_q <= vld_in;
        c_q   <= r[SW];
        s_q   <= s_nxt;
      end
    end

    if (k < NSTG - 1) begin : ops
      logic [HI-SW-1:0] a_q;
      logic [HI-SW-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[HI-1:SW];
          b_q <= b_in[HI-1:SW];
        end
      end
    end else begin : fin
      // Carry into the MSB is recovered as sum ^ a ^ b at that bit, so the
      // overflow flag needs no extra tap out of the carry chain.
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= r[SW-1] ^ a_in[SW-1] ^ b_in[SW-1] ^ r[SW];
        end
      end
    end
  end

  assign adv           = !stg[NSTG-1].vld_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = stg[NSTG-1].vld_q;
  assign bus.sum       = stg[NSTG-1].s_q;
  assign bus.cout      = stg[NSTG-1].c_q;
  assign bus.ovf       = stg[NSTG-1].fin.ovf_q;

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
module tb_carry_skip_adder_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  carry_skip_adder_pipe_if #(.WIDTH(32)) bus0 ();
  carry_skip_adder_pipe_if #(.WIDTH(16)) bus1 ();
  carry_skip_adder_pipe_if #(.WIDTH(64)) bus2 ();

  carry_skip_adder_pipe #(.WIDTH(32), .BLOCK(4), .BLOCKS_PER_STAGE(2)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  carry_skip_adder_pipe #(.WIDTH(16), .BLOCK(4), .BLOCKS_PER_STAGE(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  carry_skip_adder_pipe #(.WIDTH(64), .BLOCK(8), .BLOCKS_PER_STAGE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  localparam int NRAND = 10000;
  localparam int QD    = 16384;

  int          tests = 0;
  int          fails = 0;
  logic [65:0] exp_mem [3][QD];
  int          head    [3];
  int          tail    [3];
  int          retired [3];
  logic        hold    [3];
  logic [65:0] hold_v  [3];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer addition of the prepared operands; overflow from
  // the sign rule (same-sign operands giving a different-sign result).
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] be;
    logic [63:0] s;
    logic [64:0] full;
    logic        c0;
    logic        co;
    logic        ov;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    be   = (sub ? ~b : b) & mask;
    c0   = sub ? ~cin : cin;
    full = {1'b0, am} + {1'b0, be} + {64'd0, c0};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  // Scoreboard step for one instance, evaluated mid-cycle: retire first, then
  // record the beat the coming edge will accept.
  task automatic mon(input int id, input int w, input logic iv, input logic ir,
                     input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb,
                     input logic ov, input logic ordy, input logic [65:0] res);
    if (!rst_n) return;
    if (hold[id])
      chk($sformatf("hold%0d", id), 128'({ov, res}), 128'({1'b1, hold_v[id]}));
    if (head[id] == tail[id]) begin
      chk($sformatf("no_beat%0d", id), 128'(ov), 128'(1'b0));
    end else if (ov && ordy) begin
      chk($sformatf("result%0d", id), 128'(res), 128'(exp_mem[id][head[id] % QD]));
      head[id]++;
      retired[id]++;
    end
    hold[id]   = ov && !ordy;
    hold_v[id] = res;
    if (iv && ir) begin
      exp_mem[id][tail[id] % QD] = model(w, a, b, ci, sb);
      tail[id]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, 32, bus0.in_valid, bus0.in_ready, 64'(bus0.a), 64'(bus0.b), bus0.cin, bus0.sub,
        bus0.out_valid, bus0.out_ready, {bus0.ovf, bus0.cout, 64'(bus0.sum)});
    mon(1, 16, bus1.in_valid, bus1.in_ready, 64'(bus1.a), 64'(bus1.b), bus1.cin, bus1.sub,
        bus1.out_valid, bus1.out_ready, {bus1.ovf, bus1.cout, 64'(bus1.sum)});
    mon(2, 64, bus2.in_valid, bus2.in_ready, bus2.a, bus2.b, bus2.cin, bus2.sub,
        bus2.out_valid, bus2.out_ready, {bus2.ovf, bus2.cout, bus2.sum});
  end

  task automatic flush();
    for (int i = 0; i < 3; i++) begin
      head[i] = tail[i];
      hold[i] = 1'b0;
    end
  endtask

  // Single beat on the 32-bit unit with hand-computed result and exact latency.
  task automatic dir(input string nm, input logic [31:0] va, input logic [31:0] vb,
                     input logic vc, input logic vs,
                     input logic [31:0] es, input logic eco, input logic eov);
    int n;
    @(posedge clk); #1;
    bus0.out_ready = 1'b1;
    bus0.in_valid  = 1'b1;
    bus0.a = va; bus0.b = vb; bus0.cin = vc; bus0.sub = vs;
    @(negedge clk);
    chk({nm, "_in_ready"}, 128'(bus0.in_ready), 128'(1'b1));
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    bus0.a = ~va; bus0.b = ~vb; bus0.cin = ~vc; bus0.sub = ~vs;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.out_valid && n <= 20);
    chk({nm, "_latency"}, 128'(n), 128'(4));
    chk({nm, "_res"}, 128'({bus0.ovf, bus0.cout, bus0.sum}), 128'({eov, eco, es}));
  endtask

  function automatic logic [63:0] rnd_b(input logic [63:0] a);
    logic [63:0] r;
    case ($urandom_range(0, 3))
      0:       r = ~a;
      1:       r = ~a ^ (64'd1 << $urandom_range(0, 63));
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  initial begin
    int          n;
    int          idx;
    int          cyc;
    int          r0;
    int          base [3];
    logic        stale;
    logic [63:0] ta;
    logic [63:0] tb;

    for (int i = 0; i < 3; i++) begin
      head[i] = 0; tail[i] = 0; retired[i] = 0; hold[i] = 1'b0; hold_v[i] = '0;
    end
    rst_n = 1'b0;
    bus0.in_valid = 0; bus0.a = '0; bus0.b = '0; bus0.cin = 0; bus0.sub = 0; bus0.out_ready = 1;
    bus1.in_valid = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0; bus1.sub = 0; bus1.out_ready = 1;
    bus2.in_valid = 0; bus2.a = '0; bus2.b = '0; bus2.cin = 0; bus2.sub = 0; bus2.out_ready = 1;

    #2;
    chk("reset_out_valid", 128'(bus0.out_valid), 128'(1'b0));
    chk("reset_sum",       128'(bus0.sum),       128'(32'd0));
    chk("reset_cout_ovf",  128'({bus0.cout, bus0.ovf}), 128'(2'b00));
    chk("reset_in_ready",  128'(bus0.in_ready),  128'(1'b1));
    chk("reset_w64_valid", 128'(bus2.out_valid), 128'(1'b0));
    #10 rst_n = 1'b1;

    dir("add_5_5",      32'd5,          32'd5,          1'b1, 1'b0, 32'd11,         1'b0, 1'b0);
    dir("add_skip_all", 32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, 32'd0,          1'b1, 1'b0);
    dir("sub_3_5",      32'd3,          32'd5,          1'b0, 1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0);
    dir("sub_min_1",    32'h8000_0000,  32'd1,          1'b0, 1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1);
    dir("ovf_max_1",    32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, 32'h8000_0000,  1'b0, 1'b1);
    dir("add_ones",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0);
    dir("sub_0_0_bin",  32'd0,          32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0);
    dir("add_mixed",    32'h1234_5678,  32'h0F0F_0F0F,  1'b0, 1'b0, 32'h2143_6587,  1'b0, 1'b0);
    dir("add_cross",    32'h0000_FFFF,  32'd1,          1'b0, 1'b0, 32'h0001_0000,  1'b0, 1'b0);

    // Reset with three beats in flight and the head beat stalled at the output.
    @(posedge clk); #1;
    bus0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus0.in_valid = 1'b1;
      bus0.a = 32'h100 + 32'(i); bus0.b = 32'(i); bus0.cin = 1'b0; bus0.sub = 1'b0;
      @(posedge clk); #1;
    end
    bus0.in_valid = 1'b0;
    n = 0;
    while (!bus0.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_pre_valid", 128'(bus0.out_valid), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 128'(bus0.out_valid), 128'(1'b0));
    chk("rst_mid_sum",   128'(bus0.sum),       128'(32'd0));
    chk("rst_mid_flags", 128'({bus0.cout, bus0.ovf}), 128'(2'b00));
    chk("rst_mid_ready", 128'(bus0.in_ready),  128'(1'b1));
    flush();
    @(posedge clk); #3;
    rst_n = 1'b1;
    bus0.out_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      stale = stale | bus0.out_valid;
    end
    chk("rst_no_stale", 128'(stale), 128'(1'b0));

    // Eight back-to-back beats with the output stalled in cycles 5..7.
    r0  = retired[0];
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      bus0.out_ready = !(c >= 5 && c <= 7);
      if (idx < 8) begin
        bus0.in_valid = 1'b1;
        bus0.a   = 32'h2468_ACE1 * 32'(idx + 1);
        bus0.b   = idx[1] ? ~bus0.a : 32'h1357_9BDF * 32'(idx + 3);
        bus0.cin = idx[0];
        bus0.sub = idx[2];
      end else begin
        bus0.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 5 && c <= 7)
        chk($sformatf("bp_in_ready_c%0d", c), 128'(bus0.in_ready), 128'(1'b0));
      if (bus0.in_valid && bus0.in_ready) idx++;
    end
    chk("bp_delivered", 128'(retired[0] - r0), 128'(8));

    // Random stream on all three configurations at once.
    for (int i = 0; i < 3; i++) base[i] = tail[i];
    cyc = 0;
    while ((tail[0] - base[0] < NRAND || tail[1] - base[1] < NRAND ||
            tail[2] - base[2] < NRAND) && cyc < 40000) begin
      @(posedge clk); #1;
      cyc++;
      ta = {$urandom, $urandom}; tb = rnd_b(ta);
      bus0.in_valid = (tail[0] - base[0] < NRAND) && ($urandom_range(0, 3) != 0);
      bus0.a = ta[31:0]; bus0.b = tb[31:0];
      bus0.cin = 1'($urandom_range(0, 1)); bus0.sub = 1'($urandom_range(0, 1));
      bus0.out_ready = ($urandom_range(0, 3) != 0);
      ta = {$urandom, $urandom}; tb = rnd_b(ta);
      bus1.in_valid = (tail[1] - base[1] < NRAND) && ($urandom_range(0, 3) != 0);
      bus1.a = ta[15:0]; bus1.b = tb[15:0];
      bus1.cin = 1'($urandom_range(0, 1)); bus1.sub = 1'($urandom_range(0, 1));
      bus1.out_ready = ($urandom_range(0, 3) != 0);
      ta = {$urandom, $urandom}; tb = rnd_b(ta);
      bus2.in_valid = (tail[2] - base[2] < NRAND) && ($urandom_range(0, 3) != 0);
      bus2.a = ta; bus2.b = tb;
      bus2.cin = 1'($urandom_range(0, 1)); bus2.sub = 1'($urandom_range(0, 1));
      bus2.out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("rand_beats_w32", 128'(tail[0] - base[0]), 128'(NRAND));
    chk("rand_beats_w16", 128'(tail[1] - base[1]), 128'(NRAND));
    chk("rand_beats_w64", 128'(tail[2] - base[2]), 128'(NRAND));

    @(posedge clk); #1;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    n = 0;
    while ((head[0] != tail[0] || head[1] != tail[1] || head[2] != tail[2]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_w32", 128'(head[0]), 128'(tail[0]));
    chk("drain_w16", 128'(head[1]), 128'(tail[1]));
    chk("drain_w64", 128'(head[2]), 128'(tail[2]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
